matrix_mac_engine: RTL

//  Parametrised memory-mapped matrix multiplier: C[MxN] = A[MxK] * B[KxN]. Optionally C += A*B.

---
 rtl/matrix_mac_engine.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/matrix_mac_engine.sv
// Memory-mapped signed fixed-point matrix multiplier, C = A*B or C += A*B.
// One multiply-accumulate per cycle, with dimension checking, abort and registered readback.
module matrix_mac_engine #(
  parameter int ELEM_W  = 16,
  parameter int ACC_W   = 32,
  parameter int MAX_DIM = 8,
  parameter int ADDR_W  = 12,
  parameter int BANK    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       memory_data_in,
  input  logic [ADDR_W-1:0] memory_address,
  input  logic              write_enable,
  output logic [31:0]       memory_data_out,
  output logic              result_ready
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] B_BASE = ADDR_W'(2 + BANK);
  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(2 + 2 * BANK);
  localparam logic [ADDR_W-1:0] BANK_DEPTH = ADDR_W'(DEPTH);
  localparam logic [7:0] MAX_D8 = 8'(MAX_DIM);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MAC, S_WB, S_DONE} state_t;

  state_t r_state, w_stateNext;

  logic signed [ELEM_W-1:0] r_memA [DEPTH];
  logic signed [ELEM_W-1:0] r_memB [DEPTH];
  logic signed [ACC_W-1:0]  r_memC [DEPTH];

  logic [31:0]             r_cfg;
  logic                    r_accMode;
  logic                    r_done;
  logic                    r_error;
  logic [7:0]              r_row;
  logic [7:0]              r_col;
  logic [7:0]              r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic [31:0]             r_dataOut;

  logic [7:0] w_cfgM, w_cfgK, w_cfgRowsB, w_cfgN;
  logic w_statusWr, w_abort, w_start, w_busy, w_cfgWr, w_dimErr;
  logic w_lastK, w_lastCol, w_lastRow;
  logic [ADDR_W-1:0] w_aOff, w_bOff, w_cOff;
  logic w_aHit, w_bHit, w_cHit;
  logic [IDX_W-1:0] w_aIdx, w_bIdx, w_cIdx;
  logic signed [2*ELEM_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_accBase, w_accNext;
  logic [31:0] w_rdData;

  assign w_cfgM     = r_cfg[31:24];
  assign w_cfgK     = r_cfg[23:16];
  assign w_cfgRowsB = r_cfg[15:8];
  assign w_cfgN     = r_cfg[7:0];

  assign w_statusWr = write_enable && (memory_address == '0);
  assign w_abort    = w_statusWr && memory_data_in[29];
  assign w_start    = w_statusWr && memory_data_in[31] && !memory_data_in[29];
  assign w_cfgWr    = write_enable && (memory_address == ADDR_W'(1));
  assign w_busy     = (r_state != S_IDLE);

  // Out-of-bank addresses wrap to large offsets, so a single compare covers both ends.
  assign w_aOff = memory_address - A_BASE;
  assign w_bOff = memory_address - B_BASE;
  assign w_cOff = memory_address - C_BASE;
  assign w_aHit = (w_aOff < BANK_DEPTH);
  assign w_bHit = (w_bOff < BANK_DEPTH);
  assign w_cHit = (w_cOff < BANK_DEPTH);

  assign w_dimErr = (w_cfgM == 8'd0) || (w_cfgK == 8'd0) || (w_cfgRowsB == 8'd0) ||
                    (w_cfgN == 8'd0) || (w_cfgM > MAX_D8) || (w_cfgK > MAX_D8) ||
                    (w_cfgRowsB > MAX_D8) || (w_cfgN > MAX_D8) || (w_cfgK != w_cfgRowsB);

  assign w_lastK   = (r_k == w_cfgK - 8'd1);
  assign w_lastCol = (r_col == w_cfgN - 8'd1);
  assign w_lastRow = (r_row == w_cfgM - 8'd1);

  // Row-major packing uses the configured dimensions, so indices stay below DEPTH once checked.
  assign w_aIdx = IDX_W'(r_row * w_cfgK + r_k);
  assign w_bIdx = IDX_W'(r_k * w_cfgN + r_col);
  assign w_cIdx = IDX_W'(r_row * w_cfgN + r_col);

  assign w_prod    = r_memA[w_aIdx] * r_memB[w_bIdx];
  assign w_accBase = (r_k == 8'd0) ? (r_accMode ? r_memC[w_cIdx] : '0) : r_acc;
  assign w_accNext = w_accBase + ACC_W'(w_prod);

  assign memory_data_out = r_dataOut;
  assign result_ready    = r_done;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state logic; an abort while busy overrides the normal sequence.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_stateNext = S_CHECK;
      S_CHECK: w_stateNext = w_dimErr ? S_IDLE : S_MAC;
      S_MAC:   if (w_lastK) w_stateNext = S_WB;
      S_WB:    w_stateNext = (w_lastRow && w_lastCol) ? S_DONE : S_MAC;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
    if (w_busy && w_abort) w_stateNext = S_IDLE;
  end

  // Configuration, flags, loop counters and the running accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg     <= '0;
      r_accMode <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_k       <= '0;
      r_acc     <= '0;
    end else if (w_busy && w_abort) begin
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_accMode <= memory_data_in[30];
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
          end
          if (w_cfgWr) r_cfg <= memory_data_in;
          if (w_cfgWr || (write_enable && (w_aHit || w_bHit))) r_done <= 1'b0;
        end
        S_CHECK: if (w_dimErr) r_error <= 1'b1;
        S_MAC: begin
          r_acc <= w_accNext;
          r_k   <= w_lastK ? 8'd0 : r_k + 8'd1;
        end
        S_WB: begin
          if (w_lastCol) begin
            r_col <= '0;
            r_row <= r_row + 8'd1;
          end else begin
            r_col <= r_col + 8'd1;
          end
        end
        S_DONE: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Operand and result storage survives reset; the bus may only write it while idle.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && write_enable) begin
      if (w_aHit) r_memA[w_aOff[IDX_W-1:0]] <= memory_data_in[ELEM_W-1:0];
      if (w_bHit) r_memB[w_bOff[IDX_W-1:0]] <= memory_data_in[ELEM_W-1:0];
      if (w_cHit) r_memC[w_cOff[IDX_W-1:0]] <= memory_data_in[ACC_W-1:0];
    end else if (r_state == S_WB && !w_abort) begin
      r_memC[w_cIdx] <= r_acc;
    end
  end

  // Read decode; everything unmapped reads as zero.
  always_comb begin
    w_rdData = '0;
    if (memory_address == '0)
      w_rdData = {1'b0, r_accMode, 27'd0, w_busy, r_error, r_done};
    else if (memory_address == ADDR_W'(1))
      w_rdData = r_cfg;
    else if (w_aHit)
      w_rdData = 32'(r_memA[w_aOff[IDX_W-1:0]]);
    else if (w_bHit)
      w_rdData = 32'(r_memB[w_bOff[IDX_W-1:0]]);
    else if (w_cHit)
      w_rdData = 32'(r_memC[w_cOff[IDX_W-1:0]]);
  end

  // Registered read port, one cycle behind the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_dataOut <= '0;
    else        r_dataOut <= w_rdData;
  end

endmodule
